// File: rtl/ti_share_masker.sv
// ti_share_masker: splits each 4-bit nibble into NSHARES Boolean shares
// using fresh LFSR randomness, behind a one-entry registered valid/ready stage.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data/in_valid  unmasked nibble and its valid flag
//   in_ready          nibble accepted when in_valid && in_ready
//   out_shares        share i at bits [4i+3:4i]; XOR of all shares = nibble
//   out_valid         out_shares valid; held until out_ready
//   out_ready         downstream accepts out_shares
//   busy_warm         high while the LFSR is warming up after reset/reseed
//   seed_load/seed_val  (only with TI_MASK_RESEED_EN) runtime LFSR reseed
//
// Optional feature macro: TI_MASK_RESEED_EN
module ti_share_masker #(
    parameter int          NSHARES = 3,
    parameter logic [31:0] SEED    = 32'hACE1_2468,
    parameter int          WARMUP  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [4*NSHARES-1:0]   out_shares,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef TI_MASK_RESEED_EN
    input  logic                   seed_load,
    input  logic [31:0]            seed_val,
`endif
    output logic                   busy_warm
);

    localparam int          RW    = 4 * (NSHARES - 1);
    localparam logic [7:0]  WLAST = 8'(WARMUP - 1);

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [7:0]             cnt, cnt_n;
    logic [31:0]            lfsr, lfsr_n, lfsr_adv;
    logic                   ov_n;
    logic [4*NSHARES-1:0]   sh_n;
    logic [3:0]             s0;
    logic                   accept;
    logic                   blk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

`ifdef TI_MASK_RESEED_EN
    assign blk = seed_load;
`else
    assign blk = 1'b0;
`endif

    // Reseed blocks acceptance combinationally so it wins over an input.
    assign in_ready  = (state == RUN) && (!out_valid || out_ready) && !blk;
    assign busy_warm = (state == WARM);
    assign accept    = in_valid && in_ready;

    // RW single steps unrolled; consumed only on an accept.
    always_comb begin
        lfsr_adv = lfsr;
        for (int i = 0; i < RW; i++) begin
            lfsr_adv = lfsr_step(lfsr_adv);
        end
    end

    // s_1..s_{n-1} are the raw random nibbles; s_0 absorbs the data.
    always_comb begin
        sh_n = out_shares;
        s0   = in_data;
        for (int i = 1; i < NSHARES; i++) begin
            sh_n[4*i +: 4] = lfsr[4*(i-1) +: 4];
            s0             = s0 ^ lfsr[4*(i-1) +: 4];
        end
        sh_n[3:0] = s0;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lfsr_n  = lfsr;
        ov_n    = out_valid && !out_ready;
        unique case (state)
            WARM: begin
                lfsr_n = lfsr_step(lfsr);
                cnt_n  = cnt + 8'd1;
                if (cnt == WLAST) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    lfsr_n = lfsr_adv;
                    ov_n   = 1'b1;
                end
            end
            default: state_n = WARM;
        endcase
        // An all-zero LFSR would lock up; fall back to the seed.
        if (lfsr_n == 32'd0) begin
            lfsr_n = SEED;
        end
`ifdef TI_MASK_RESEED_EN
        if (seed_load) begin
            lfsr_n  = (seed_val == 32'd0) ? SEED : seed_val;
            cnt_n   = 8'd0;
            state_n = WARM;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WARM;
            cnt        <= 8'd0;
            lfsr       <= SEED;
            out_valid  <= 1'b0;
            out_shares <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lfsr      <= lfsr_n;
            out_valid <= ov_n;
            if (accept) begin
                out_shares <= sh_n;
            end
        end
    end

endmodule

// File: tb/tb_ti_share_masker.sv
// tb_ti_share_masker: randomized and directed stimulus for ti_share_masker,
// checked every cycle against a transaction-level model of the masker.
module tb_ti_share_masker;

    localparam int          NS   = 3;
    localparam int          RW   = 4 * (NS - 1);
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam int          WU   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      in_data = 4'd0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4*NS-1:0] out_shares;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            busy_warm;
    logic            seed_load = 1'b0;
    logic [31:0]     seed_val = 32'd0;

    int vectors = 0;
    int errors  = 0;

    // model state
    int              m_warm;
    logic [31:0]     m_l;
    logic            m_ov;
    logic [4*NS-1:0] m_sh;
    logic [3:0]      m_nib;

    ti_share_masker #(.NSHARES(NS), .SEED(SEED), .WARMUP(WU)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_shares(out_shares),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef TI_MASK_RESEED_EN
        .seed_load(seed_load),
        .seed_val(seed_val),
`endif
        .busy_warm(busy_warm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] step(input logic [31:0] l);
        logic nb;
        nb = l[31] ^ l[21] ^ l[1] ^ l[0];
        return {l[30:0], nb};
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] l, input int n);
        logic [31:0] x;
        x = l;
        for (int i = 0; i < n; i++) x = step(x);
        return x;
    endfunction

    function automatic logic m_rdy();
        return (m_warm == 0) && (!m_ov || out_ready) && !seed_load;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Transaction-level model: warm-up countdown, then one nibble per
    // accept using the low RW random bits and advancing RW steps.
    always @(posedge clk) begin
        logic        acc;
        logic [3:0]  x;
        logic [31:0] nl;
        if (rst) begin
            m_warm = WU;
            m_l    = SEED;
            m_ov   = 1'b0;
            m_sh   = '0;
        end else begin
            acc  = in_valid && m_rdy();
            m_ov = m_ov && !out_ready;
            if (seed_load) begin
                m_l    = (seed_val == 0) ? SEED : seed_val;
                m_warm = WU;
            end else if (m_warm > 0) begin
                m_l    = step(m_l);
                m_warm = m_warm - 1;
            end else if (acc) begin
                x = in_data;
                for (int i = 1; i < NS; i++) begin
                    m_sh[4*i +: 4] = m_l[4*(i-1) +: 4];
                    x = x ^ m_l[4*(i-1) +: 4];
                end
                m_sh[3:0] = x;
                m_nib     = in_data;
                nl        = adv(m_l, RW);
                m_l       = (nl == 0) ? SEED : nl;
                m_ov      = 1'b1;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] xr;
        if (!rst) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("in_ready", 32'(in_ready), 32'(m_rdy()));
            chk("busy_warm", 32'(busy_warm), 32'(m_warm > 0));
            chk("out_shares", 32'(out_shares), 32'(m_sh));
            if (out_valid) begin
                xr = 4'd0;
                for (int i = 0; i < NS; i++) xr ^= out_shares[4*i +: 4];
                chk("share_xor", 32'(xr), 32'(m_nib));
            end
        end
    end

    task automatic cyc(input logic v, input logic [3:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int outs;
        // pin the model's LFSR taps with hand-computed steps
        chk("step_seed", step(SEED), 32'h59C2_48D0);
        chk("step_1", step(32'h0000_0001), 32'h0000_0003);
        chk("step_msb", step(32'h8000_0000), 32'h0000_0001);
        chk("step_b21", step(32'h0020_0000), 32'h0040_0001);

        do_reset();
        chk("rst_shares", 32'(out_shares), 32'd0);
        chk("rst_busy", 32'(busy_warm), 32'd1);
        // in_ready must first rise on the 17th cycle after reset release
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                k = i;
                break;
            end
        end
        chk("warm_len", 32'(k), 32'd17);
        @(posedge clk);
        #1;

        // single accept of 4'hA
        cyc(1'b1, 4'hA, 1'b1);
        cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b0, 4'h0, 1'b1);

        // back-to-back stream 0..F, count output cycles
        outs = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 4'(i), 1'b1);
            if (out_valid) outs++;
        end
        cyc(1'b0, 4'h0, 1'b1);
        chk("stream_outs", 32'(outs), 32'd16);

        // stall for 5 cycles, then drain and accept on one edge
        cyc(1'b1, 4'h5, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'h9, 1'b0);
        cyc(1'b1, 4'h3, 1'b1);
        cyc(1'b0, 4'h0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom),
                1'($urandom_range(0, 3) != 0));

        // reset with a buffered output
        cyc(1'b1, 4'hC, 1'b0);
        cyc(1'b0, 4'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_busy2", 32'(busy_warm), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'hA, 1'b1);
        cyc(1'b0, 4'h0, 1'b1);

`ifdef TI_MASK_RESEED_EN
        // reseed with zero while an output is held and input is offered
        cyc(1'b1, 4'h7, 1'b0);
        seed_load = 1'b1;
        seed_val  = 32'd0;
        cyc(1'b1, 4'h2, 1'b0);
        seed_load = 1'b0;
        cyc(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'h0, 1'b1);
        seed_load = 1'b1;
        seed_val  = 32'h1357_9BDF;
        cyc(1'b0, 4'h0, 1'b1);
        seed_load = 1'b0;
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), 4'($urandom),
                1'($urandom_range(0, 1)));
`endif

        for (int i = 0; i < 500; i++)
            cyc(1'($urandom_range(0, 1)), 4'($urandom), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 errors);
        $finish;
    end

endmodule
